// File: rtl/multi_clk_div.sv
// rtl/multi_clk_div.sv - multi-channel programmable clock divider with per-channel strobe and square wave
// Optional feature macro: MULTI_CLK_DIV_SYNC_EN adds the iSync re-phase input.
module multi_clk_div #(
  parameter int Channels   = 4,
  parameter int Width      = 16,
  parameter int DefaultDiv = 2,
  localparam int ChanW     = (Channels > 1) ? $clog2(Channels) : 1
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [Channels-1:0] iEnable,
  input  logic                iWrEn,
  input  logic [ChanW-1:0]    iWrChan,
  input  logic [Width-1:0]    iWrDiv,
`ifdef MULTI_CLK_DIV_SYNC_EN
  input  logic                iSync,
`endif
  output logic                oWrAck,
  output logic [Channels-1:0] oStrobe,
  output logic [Channels-1:0] oClk
);

  localparam logic [Width-1:0] ResetDiv = Width'(DefaultDiv);
  localparam logic [ChanW:0]   NumChan  = (ChanW + 1)'(Channels);

  logic wrValid;
  logic syncNow;

  // A write only counts when it addresses an existing channel
  assign wrValid = iWrEn && ({1'b0, iWrChan} < NumChan);

`ifdef MULTI_CLK_DIV_SYNC_EN
  assign syncNow = iSync;
`else
  assign syncNow = 1'b0;
`endif

  // Acknowledge accepted writes one cycle after the strobe
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oWrAck <= 1'b0;
    end else begin
      oWrAck <= wrValid;
    end
  end

  for (genvar n = 0; n < Channels; n++) begin : gChan
    logic [Width-1:0] count;
    logic [Width-1:0] divAct;
    logic [Width-1:0] divPend;
    logic             pending;
    logic             strobeR;
    logic             clkR;
    logic             wrHit;
    logic             clear;
    logic             halted;
    logic             termCnt;
    logic             xfer;

    // Decode this channel's write, terminal count and divisor hand-over point
    always_comb begin
      wrHit   = wrValid && (iWrChan == ChanW'(n));
      clear   = syncNow || !iEnable[n];
      halted  = (divAct == '0);
      termCnt = !clear && !halted && (count == divAct - 1'b1);
      xfer    = pending && (clear || halted || termCnt);
    end

    // Counter, strobe and square wave; new divisor only takes over at a period boundary
    always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
        count   <= '0;
        divAct  <= ResetDiv;
        divPend <= ResetDiv;
        pending <= 1'b0;
        strobeR <= 1'b0;
        clkR    <= 1'b0;
      end else begin
        if (wrHit) begin
          divPend <= iWrDiv;
        end
        if (xfer) begin
          divAct <= divPend;
        end
        pending <= wrHit || (pending && !xfer);
        if (clear) begin
          count   <= '0;
          strobeR <= 1'b0;
          clkR    <= 1'b0;
        end else begin
          clkR    <= clkR ^ strobeR;
          strobeR <= termCnt;
          if (halted || termCnt) begin
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
      end
    end

    assign oStrobe[n] = strobeR;
    assign oClk[n]    = clkR;
  end

endmodule

// File: doc/multi_clk_div.md
MULTI_CLK_DIV -- requirements
Module: multi_clk_div

Interface
REQ-001 SHALL have parameter Channels, 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter Width, 16, divisor/counter width in bits (2..32).
REQ-003 SHALL have parameter DefaultDiv, 2, divisor loaded into every channel at reset (0..2^Width-1).
REQ-004 SHALL have port iClk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port iRst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port iEnable  input  Channels  per-channel run enable, bit n = channel n.
REQ-007 SHALL have port iWrEn  input  1  divisor write strobe, one write per asserted cycle.
REQ-008 SHALL have port iWrChan  input  max(1,$clog2(Channels))  target channel of write.
REQ-009 SHALL have port iWrDiv  input  Width  new divisor value.
REQ-010 SHALL have port oWrAck  output  1  one-cycle pulse when a write is accepted.
REQ-011 SHALL have port oStrobe  output  Channels  one-cycle clock-enable pulse per channel period.
REQ-012 SHALL have port oClk  output  Channels  registered square wave per channel, toggles on each strobe.

Function
REQ-013 SHALL keep per channel an active divisor D, a pending divisor P, a pending flag and a counter C of Width bits.
REQ-014 SHALL, with iEnable[n]=1 and D>=1, count C 0..D-1, assert oStrobe[n] in the cycle C==D-1 and wrap C to 0 in the next cycle; strobe period = D cycles, D=1 gives oStrobe[n] high every cycle.
REQ-015 SHALL toggle oClk[n] in the cycle after each oStrobe[n] pulse; oClk[n] period = 2*D cycles.
REQ-016 SHALL treat D=0 as channel halted: C held at 0, oStrobe[n]=0, oClk[n] held.
REQ-017 SHALL, on iWrEn=1 with iWrChan<Channels, register iWrDiv into P of that channel, set its pending flag and pulse oWrAck one cycle later.
REQ-018 SHALL ignore writes with iWrChan>=Channels: no state change, oWrAck stays 0.
REQ-019 SHALL transfer P to D (and clear pending) at the wrap following the strobe cycle, so the period in progress always completes at the old divisor.
REQ-020 SHALL transfer P to D on the next cycle if the channel is disabled or D=0, without waiting for a wrap.
REQ-021 SHALL let the last write win when several writes to one channel arrive before transfer.
REQ-022 SHALL, when iEnable[n]=0, clear C, force oStrobe[n]=0 and clear oClk[n] on the next edge; re-enable starts counting from C=0 with oStrobe[n] first asserted D cycles after the enable edge.
REQ-023 SHALL keep all channels fully independent; a write or enable change on one channel SHALL NOT alter any other channel's counter or outputs.
REQ-024 SHALL produce all outputs from registers (no combinational path from inputs to outputs).

Reset
REQ-025 SHALL, while iRst=1, asynchronously force C=0, D=DefaultDiv, P=DefaultDiv, pending=0, oStrobe=0, oClk=0, oWrAck=0.
REQ-026 SHALL discard any pending write when iRst asserts mid-operation; first oStrobe after release occurs DefaultDiv cycles after the first enabled edge.

Configuration
REQ-027 SHALL, when macro MULTI_CLK_DIV_SYNC_EN is defined, add port iSync input 1: a high cycle clears C of every channel, clears every oClk and suppresses oStrobe in that cycle, and also performs any pending divisor transfer.
REQ-028 SHALL give iSync priority over a coincident terminal count (no strobe, no toggle) and over a coincident write (write still lands in P, oWrAck still pulses).
REQ-029 SHALL, when MULTI_CLK_DIV_SYNC_EN is undefined, omit port iSync and all associated logic.

Verification
REQ-030 SHALL cover: reset release, iEnable=4'b0001, DefaultDiv=2 -> oStrobe[0] every 2nd cycle, oClk[0] period 4, channels 1-3 silent.
REQ-031 SHALL cover: channel 0 running D=2, write iWrChan=0 iWrDiv=5 mid-period -> oWrAck pulse next cycle; current period ends at 2; following strobes every 5 cycles.
REQ-032 SHALL cover: two writes to channel 1 (7 then 3) before wrap -> active divisor becomes 3; write with iWrChan=5 (Channels=4) -> no oWrAck, no change.
REQ-033 SHALL cover: write iWrDiv=0 to running channel 2 -> halts after current period, oClk[2] frozen; write 1 -> oStrobe[2] high every cycle.
REQ-034 SHALL cover: iEnable[3] dropped mid-count then raised -> oStrobe[3]=0 and oClk[3]=0 while low; first strobe D cycles after re-enable.
REQ-035 SHALL cover (MULTI_CLK_DIV_SYNC_EN defined): channels D=3 and D=4 free-running, iSync pulse coincident with a terminal count -> no strobe that cycle, all oClk=0, channels re-phase-aligned from C=0.
